instruction_fetch: RTL and testbench
====================================

# instruction_fetch

Instruction fetch unit: the initiator that drives the byte-addressed instruction memory port and feeds the decode stage. It holds the fetch PC, issues one word request at a time, buffers returned instructions with their PCs in a small FIFO, and back-pressures on decode stalls. A redirect from execute (branch, jump or trap) flushes the buffer and discards any in-flight response.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000: first fetch address after reset; must be 4-byte aligned.
- DEPTH, 2: instruction buffer entries; must be a power of 2, ≥2.

Ports:
- i_clk  in  1  clock; all state changes on the rising edge.
- i_rst  in  1  asynchronous, active-high reset.
- o_IMEM_Addr  out  `XLEN  byte address of the requested word, always 4-byte aligned.
- o_IMEM_Req  out  1  request valid.
- i_IMEM_Ack  in  1  memory accepts the request and returns data in the same cycle; may be tied to o_IMEM_Req.
- i_IMEM_Data  in  32  instruction word, sampled only when Req & Ack.
- o_Instr  out  32  instruction at the buffer head.
- o_PC  out  `XLEN  PC of o_Instr.
- o_Valid  out  1  buffer head valid.
- i_Ready  in  1  decode consumes the head when o_Valid & i_Ready (pop).
- i_Redirect  in  1  single-cycle redirect strobe.
- i_Redirect_PC  in  `XLEN  new fetch PC, sampled when i_Redirect = 1.
- o_Misaligned  out  1  sticky misaligned-target flag (present only with the macro).
- o_Bad_PC  out  `XLEN  offending redirect target (present only with the macro).

## Operation
- Registers: fetch PC, FIFO (instruction and PC per entry), occupancy count (0..DEPTH), FSM state.
- FSM states:
  - FETCH: normal operation.
  - DRAIN: an in-flight response is discarded.
  - HALT: misaligned target; present only with the macro.
- Request rule in FETCH:
  - Raise o_IMEM_Req when count − pop < DEPTH.
  - Once raised, Req and Addr stay stable until Ack, regardless of i_Ready.
- Handshake: Req & Ack pushes {i_IMEM_Data, fetch PC} and advances fetch PC by 4, with 32-bit wrap-around (0xFFFF_FFFC → 0).
- Push and pop may occur in the same cycle; count is unchanged. A full buffer with a pop in that cycle accepts a push.
- Redirect:
  - Highest priority. Flushes the FIFO (count := 0) and sets fetch PC := i_Redirect_PC.
  - Any same-cycle push is dropped and any same-cycle pop is ignored.
  - If Req is high without Ack in the redirect cycle, go to DRAIN. DRAIN keeps Req and the old Addr until Ack, drops that data, then returns to FETCH and requests the new PC.
  - If Ack coincides with the redirect, that data is dropped and the FSM stays in FETCH.
  - A redirect during DRAIN updates the target and stays in DRAIN.
- Output path: o_Instr, o_PC and o_Valid are driven from the FIFO head; there is no combinational path from i_IMEM_Data to o_Instr.

## Timing
- Reset values:
  - o_IMEM_Req = 0, o_IMEM_Addr = RESET_PC.
  - o_Valid = 0, o_Instr = 0, o_PC = 0.
  - o_Misaligned = 0, o_Bad_PC = 0.
  - Count 0, state FETCH.
- First cycle after i_rst deasserts: Req = 1, Addr = RESET_PC.
- Latency: Ack in cycle N makes o_Valid = 1 in cycle N+1.
- Throughput: 1 instruction/cycle with Ack tied high and i_Ready = 1.
- Redirect in cycle N (no pending request): Req at the new PC in N+1, first new o_Valid in N+2. o_Valid = 0 in N+1.
- Reset asserted mid-operation: immediate return to reset values; the in-flight request is abandoned.

## Configuration
- ARVI_FETCH_MISALIGN_CHECK_EN defined:
  - A redirect with i_Redirect_PC[1:0] ≠ 0 flushes the buffer and enters HALT.
  - o_Misaligned := 1 and o_Bad_PC := i_Redirect_PC.
  - In HALT, Req = 0 (after any DRAIN completes).
  - An aligned redirect clears o_Misaligned and resumes FETCH.
- Undefined: bits [1:0] of i_Redirect_PC are forced to 0. The o_Misaligned and o_Bad_PC ports and the HALT state do not exist.

## Test plan
- Reset, Ack tied to Req, i_Ready = 1, memory word at address n = n → Addr 0, 4, 8… on consecutive cycles. o_Valid rises in cycle 2 after reset deassertion, then o_PC 0, 4, 8 with matching o_Instr.
- i_Ready = 0 for 5 cycles with DEPTH = 2 → exactly 2 pushes, then Req = 0. On release, o_PC continues 0, 4, 8 with no loss or duplication.
- Ack delayed 3 cycles, redirect to 0x100 in the first wait cycle → Addr held until Ack and that data dropped. Next Req Addr = 0x100, first o_PC = 0x100.
- Redirect in the same cycle as Ack and pop with a full buffer → count = 0 next cycle, o_Valid = 0, then o_PC = target.
- Redirect to 0xFFFF_FFF8 → o_PC sequence 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0.
- Macro defined: redirect to 0x102 → o_Misaligned = 1, o_Bad_PC = 0x102, Req = 0. Redirect to 0x200 → flag cleared, o_PC = 0x200. Macro undefined: same stimulus gives o_PC = 0x100.

Source files
------------

// File: rtl/instruction_fetch_if.sv
// Fetch-unit bus: instruction-memory request/response plus decode and redirect side.
// ARVI_FETCH_MISALIGN_CHECK_EN adds the misaligned-redirect status signals.
`ifndef XLEN
`define XLEN 32
`endif

interface instruction_fetch_if;
  logic [`XLEN-1:0] o_IMEM_Addr;
  logic             o_IMEM_Req;
  logic             i_IMEM_Ack;
  logic [31:0]      i_IMEM_Data;
  logic [31:0]      o_Instr;
  logic [`XLEN-1:0] o_PC;
  logic             o_Valid;
  logic             i_Ready;
  logic             i_Redirect;
  logic [`XLEN-1:0] i_Redirect_PC;
`ifdef ARVI_FETCH_MISALIGN_CHECK_EN
  logic             o_Misaligned;
  logic [`XLEN-1:0] o_Bad_PC;
`endif

  modport master (
    output o_IMEM_Addr, o_IMEM_Req, o_Instr, o_PC, o_Valid,
`ifdef ARVI_FETCH_MISALIGN_CHECK_EN
    output o_Misaligned, o_Bad_PC,
`endif
    input  i_IMEM_Ack, i_IMEM_Data, i_Ready, i_Redirect, i_Redirect_PC
  );

  modport slave (
    input  o_IMEM_Addr, o_IMEM_Req, o_Instr, o_PC, o_Valid,
`ifdef ARVI_FETCH_MISALIGN_CHECK_EN
    input  o_Misaligned, o_Bad_PC,
`endif
    output i_IMEM_Ack, i_IMEM_Data, i_Ready, i_Redirect, i_Redirect_PC
  );
endinterface

// File: rtl/instruction_fetch.sv
// Instruction fetch: one outstanding word request, DEPTH-entry {instr, pc} buffer, redirect flush.
// ARVI_FETCH_MISALIGN_CHECK_EN enables the HALT state on misaligned redirect targets.
module instruction_fetch #(
  parameter logic [`XLEN-1:0] RESET_PC = '0,
  parameter int               DEPTH    = 2
) (
  input  logic                i_clk,
  input  logic                i_rst,
  instruction_fetch_if.master bus
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

`ifdef ARVI_FETCH_MISALIGN_CHECK_EN
  typedef enum logic [1:0] {S_FETCH, S_DRAIN, S_HALT} state_t;
`else
  typedef enum logic [0:0] {S_FETCH, S_DRAIN} state_t;
`endif

  state_t           state_q, state_d;
  logic [`XLEN-1:0] pc_q, pc_d, drain_addr_q, drain_addr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
  logic [31:0]      instr_q [DEPTH];
  logic [`XLEN-1:0] ipc_q   [DEPTH];
  logic             valid, head_pop, pop, req, ack, push;
  logic [`XLEN-1:0] target;

`ifdef ARVI_FETCH_MISALIGN_CHECK_EN
  logic             misaligned_q, misaligned_d, bad_tgt;
  logic [`XLEN-1:0] bad_pc_q, bad_pc_d;
  assign target  = bus.i_Redirect_PC;
  assign bad_tgt = |bus.i_Redirect_PC[1:0];
`else
  logic unused_lsb;
  assign unused_lsb = ^bus.i_Redirect_PC[1:0];
  assign target     = {bus.i_Redirect_PC[`XLEN-1:2], 2'b00};
`endif

  assign valid    = (count_q != '0);
  assign head_pop = valid & bus.i_Ready;
  assign pop      = head_pop & ~bus.i_Redirect;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    drain_addr_d = drain_addr_q;
    count_d      = count_q;
    req          = 1'b0;
    ack          = 1'b0;
    push         = 1'b0;
`ifdef ARVI_FETCH_MISALIGN_CHECK_EN
    misaligned_d = misaligned_q;
    bad_pc_d     = bad_pc_q;
`endif
    // A slot freed by this cycle's pop may be refilled in the same cycle.
    case (state_q)
      S_FETCH: req = ~i_rst & ((count_q < DEPTH_C) | head_pop);
      S_DRAIN: req = ~i_rst;
      default: req = 1'b0;
    endcase
    ack = req & bus.i_IMEM_Ack;

    if (bus.i_Redirect) begin
      pc_d    = target;
      count_d = '0;
      if (req && !ack) begin
        state_d = S_DRAIN;
        if (state_q == S_FETCH) drain_addr_d = pc_q;
      end else begin
        state_d = S_FETCH;
`ifdef ARVI_FETCH_MISALIGN_CHECK_EN
        if (bad_tgt) state_d = S_HALT;
`endif
      end
`ifdef ARVI_FETCH_MISALIGN_CHECK_EN
      misaligned_d = bad_tgt;
      if (bad_tgt) bad_pc_d = bus.i_Redirect_PC;
`endif
    end else begin
      if (state_q == S_FETCH && ack) begin
        push = 1'b1;
        pc_d = pc_q + `XLEN'd4;
      end
      if (state_q == S_DRAIN && ack) begin
        state_d = S_FETCH;
`ifdef ARVI_FETCH_MISALIGN_CHECK_EN
        if (misaligned_q) state_d = S_HALT;
`endif
      end
      if (push && !pop)      count_d = count_q + CNT_ONE;
      else if (pop && !push) count_d = count_q - CNT_ONE;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q      <= S_FETCH;
      pc_q         <= RESET_PC;
      drain_addr_q <= RESET_PC;
      count_q      <= '0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        instr_q[i] <= '0;
        ipc_q[i]   <= '0;
      end
`ifdef ARVI_FETCH_MISALIGN_CHECK_EN
      misaligned_q <= 1'b0;
      bad_pc_q     <= '0;
`endif
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      drain_addr_q <= drain_addr_d;
      count_q      <= count_d;
`ifdef ARVI_FETCH_MISALIGN_CHECK_EN
      misaligned_q <= misaligned_d;
      bad_pc_q     <= bad_pc_d;
`endif
      if (bus.i_Redirect) begin
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
      end else begin
        if (push) begin
          instr_q[wr_ptr_q] <= bus.i_IMEM_Data;
          ipc_q[wr_ptr_q]   <= pc_q;
          wr_ptr_q          <= wr_ptr_q + PTR_ONE;
        end
        if (pop) rd_ptr_q <= rd_ptr_q + PTR_ONE;
      end
    end
  end

  assign bus.o_IMEM_Req  = req;
  assign bus.o_IMEM_Addr = (state_q == S_DRAIN) ? drain_addr_q : pc_q;
  assign bus.o_Valid     = valid;
  assign bus.o_Instr     = instr_q[rd_ptr_q];
  assign bus.o_PC        = ipc_q[rd_ptr_q];
`ifdef ARVI_FETCH_MISALIGN_CHECK_EN
  assign bus.o_Misaligned = misaligned_q;
  assign bus.o_Bad_PC     = bad_pc_q;
`endif
endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed scenarios plus a randomized run
// checked against an in-order instruction-stream model.
module tb_instruction_fetch;
  logic i_clk = 1'b0;
  logic i_rst;
  logic ack_tie, ack_man;
  int   n_checks = 0;
  int   n_fail = 0;

  instruction_fetch_if bus();

  instruction_fetch #(.RESET_PC(32'h0), .DEPTH(2)) dut (
    .i_clk(i_clk),
    .i_rst(i_rst),
    .bus  (bus.master)
  );

  always #5 i_clk = ~i_clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  always_comb begin
    bus.i_IMEM_Ack  = ack_tie ? bus.o_IMEM_Req : ack_man;
    bus.i_IMEM_Data = mem_word(bus.o_IMEM_Addr);
  end

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic test_reset();
    i_rst = 1'b1; ack_tie = 1'b1; ack_man = 1'b0;
    bus.i_Ready = 1'b1; bus.i_Redirect = 1'b0; bus.i_Redirect_PC = '0;
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    n_checks++; if (bus.o_IMEM_Req !== 1'b0) begin n_fail++; $display("FAIL rst_req got %0h want 0", bus.o_IMEM_Req); end
    n_checks++; if (bus.o_IMEM_Addr !== 32'h0) begin n_fail++; $display("FAIL rst_addr got %h want 0", bus.o_IMEM_Addr); end
    n_checks++; if (bus.o_Valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid got %0h want 0", bus.o_Valid); end
    n_checks++; if (bus.o_Instr !== 32'h0) begin n_fail++; $display("FAIL rst_instr got %h want 0", bus.o_Instr); end
    n_checks++; if (bus.o_PC !== 32'h0) begin n_fail++; $display("FAIL rst_pc got %h want 0", bus.o_PC); end
`ifdef ARVI_FETCH_MISALIGN_CHECK_EN
    n_checks++; if (bus.o_Misaligned !== 1'b0) begin n_fail++; $display("FAIL rst_mis got %0h want 0", bus.o_Misaligned); end
    n_checks++; if (bus.o_Bad_PC !== 32'h0) begin n_fail++; $display("FAIL rst_badpc got %h want 0", bus.o_Bad_PC); end
`endif
    @(posedge i_clk); #1 i_rst = 1'b0;
    @(negedge i_clk);
    n_checks++; if (bus.o_IMEM_Req !== 1'b1 || bus.o_IMEM_Addr !== 32'h0) begin n_fail++; $display("FAIL first_req got req=%0h addr=%h want 1/0", bus.o_IMEM_Req, bus.o_IMEM_Addr); end
    n_checks++; if (bus.o_Valid !== 1'b0) begin n_fail++; $display("FAIL first_valid got %0h want 0", bus.o_Valid); end
    for (int k = 0; k < 8; k++) begin
      step();
      @(negedge i_clk);
      n_checks++; if (bus.o_Valid !== 1'b1) begin n_fail++; $display("FAIL stream_valid k=%0d got %0h want 1", k, bus.o_Valid); end
      n_checks++; if (bus.o_PC !== 32'(4 * k)) begin n_fail++; $display("FAIL stream_pc k=%0d got %h want %h", k, bus.o_PC, 32'(4 * k)); end
      n_checks++; if (bus.o_Instr !== mem_word(32'(4 * k))) begin n_fail++; $display("FAIL stream_instr k=%0d got %h want %h", k, bus.o_Instr, mem_word(32'(4 * k))); end
      n_checks++; if (bus.o_IMEM_Addr !== 32'(4 * k + 4)) begin n_fail++; $display("FAIL stream_addr k=%0d got %h want %h", k, bus.o_IMEM_Addr, 32'(4 * k + 4)); end
    end
  endtask

  task automatic test_reset_mid();
    step();
    #2 i_rst = 1'b1;
    #1;
    n_checks++; if (bus.o_IMEM_Req !== 1'b0) begin n_fail++; $display("FAIL midrst_req got %0h want 0", bus.o_IMEM_Req); end
    n_checks++; if (bus.o_Valid !== 1'b0) begin n_fail++; $display("FAIL midrst_valid got %0h want 0", bus.o_Valid); end
    n_checks++; if (bus.o_IMEM_Addr !== 32'h0) begin n_fail++; $display("FAIL midrst_addr got %h want 0", bus.o_IMEM_Addr); end
    n_checks++; if (bus.o_PC !== 32'h0 || bus.o_Instr !== 32'h0) begin n_fail++; $display("FAIL midrst_head got pc=%h instr=%h want 0/0", bus.o_PC, bus.o_Instr); end
  endtask

  task automatic test_backpressure();
    int pushes, pops;
    logic [31:0] exp_pc;
    i_rst = 1'b1; ack_tie = 1'b1; bus.i_Ready = 1'b0;
    @(posedge i_clk); #1 i_rst = 1'b0;
    pushes = 0;
    for (int c = 0; c < 5; c++) begin
      if (c > 0) step();
      @(negedge i_clk);
      if (bus.o_IMEM_Req && bus.i_IMEM_Ack) pushes++;
    end
    n_checks++; if (pushes != 2) begin n_fail++; $display("FAIL bp_pushes got %0d want 2", pushes); end
    n_checks++; if (bus.o_IMEM_Req !== 1'b0) begin n_fail++; $display("FAIL bp_req_full got %0h want 0", bus.o_IMEM_Req); end
    n_checks++; if (bus.o_Valid !== 1'b1 || bus.o_PC !== 32'h0) begin n_fail++; $display("FAIL bp_head got v=%0h pc=%h want 1/0", bus.o_Valid, bus.o_PC); end
    step();
    bus.i_Ready = 1'b1;
    exp_pc = 32'h0; pops = 0;
    for (int c = 0; c < 12 && pops < 6; c++) begin
      if (c > 0) step();
      @(negedge i_clk);
      if (c == 0) begin
        n_checks++; if (bus.o_IMEM_Req !== 1'b1) begin n_fail++; $display("FAIL bp_full_pop_req got %0h want 1", bus.o_IMEM_Req); end
      end
      if (bus.o_Valid && bus.i_Ready) begin
        n_checks++; if (bus.o_PC !== exp_pc || bus.o_Instr !== mem_word(exp_pc)) begin n_fail++; $display("FAIL bp_order got pc=%h instr=%h want pc=%h", bus.o_PC, bus.o_Instr, exp_pc); end
        exp_pc += 32'd4; pops++;
      end
    end
    n_checks++; if (pops != 6) begin n_fail++; $display("FAIL bp_release_pops got %0d want 6", pops); end
  endtask

  task automatic test_drain();
    i_rst = 1'b1; ack_tie = 1'b0; ack_man = 1'b0; bus.i_Ready = 1'b1;
    @(posedge i_clk); #1 i_rst = 1'b0;
    bus.i_Redirect = 1'b1; bus.i_Redirect_PC = 32'h100;
    @(negedge i_clk);
    n_checks++; if (bus.o_IMEM_Req !== 1'b1 || bus.o_IMEM_Addr !== 32'h0) begin n_fail++; $display("FAIL drain_c1 got req=%0h addr=%h want 1/0", bus.o_IMEM_Req, bus.o_IMEM_Addr); end
    for (int w = 0; w < 2; w++) begin
      step();
      bus.i_Redirect = 1'b0;
      @(negedge i_clk);
      n_checks++; if (bus.o_IMEM_Req !== 1'b1 || bus.o_IMEM_Addr !== 32'h0 || bus.o_Valid !== 1'b0) begin n_fail++; $display("FAIL drain_hold w=%0d got req=%0h addr=%h v=%0h want 1/0/0", w, bus.o_IMEM_Req, bus.o_IMEM_Addr, bus.o_Valid); end
    end
    step();
    ack_man = 1'b1;
    @(negedge i_clk);
    n_checks++; if (bus.o_IMEM_Req !== 1'b1 || bus.o_IMEM_Addr !== 32'h0) begin n_fail++; $display("FAIL drain_ack got req=%0h addr=%h want 1/0", bus.o_IMEM_Req, bus.o_IMEM_Addr); end
    step();
    ack_man = 1'b0; ack_tie = 1'b1;
    @(negedge i_clk);
    n_checks++; if (bus.o_Valid !== 1'b0) begin n_fail++; $display("FAIL drain_dropped got v=%0h want 0", bus.o_Valid); end
    n_checks++; if (bus.o_IMEM_Req !== 1'b1 || bus.o_IMEM_Addr !== 32'h100) begin n_fail++; $display("FAIL drain_newreq got req=%0h addr=%h want 1/100", bus.o_IMEM_Req, bus.o_IMEM_Addr); end
    step();
    @(negedge i_clk);
    n_checks++; if (bus.o_Valid !== 1'b1 || bus.o_PC !== 32'h100 || bus.o_Instr !== mem_word(32'h100)) begin n_fail++; $display("FAIL drain_first got v=%0h pc=%h instr=%h want 1/100", bus.o_Valid, bus.o_PC, bus.o_Instr); end
  endtask

  task automatic test_redirect_full();
    step();
    bus.i_Ready = 1'b0;
    repeat (2) begin @(negedge i_clk); step(); end
    @(negedge i_clk);
    n_checks++; if (bus.o_IMEM_Req !== 1'b0 || bus.o_Valid !== 1'b1) begin n_fail++; $display("FAIL rf_full got req=%0h v=%0h want 0/1", bus.o_IMEM_Req, bus.o_Valid); end
    step();
    bus.i_Ready = 1'b1; bus.i_Redirect = 1'b1; bus.i_Redirect_PC = 32'h40;
    @(negedge i_clk);
    n_checks++; if (bus.o_IMEM_Req !== 1'b1 || bus.i_IMEM_Ack !== 1'b1) begin n_fail++; $display("FAIL rf_coincide got req=%0h ack=%0h want 1/1", bus.o_IMEM_Req, bus.i_IMEM_Ack); end
    step();
    bus.i_Redirect = 1'b0;
    @(negedge i_clk);
    n_checks++; if (bus.o_Valid !== 1'b0) begin n_fail++; $display("FAIL rf_flush got v=%0h want 0", bus.o_Valid); end
    n_checks++; if (bus.o_IMEM_Req !== 1'b1 || bus.o_IMEM_Addr !== 32'h40) begin n_fail++; $display("FAIL rf_newreq got req=%0h addr=%h want 1/40", bus.o_IMEM_Req, bus.o_IMEM_Addr); end
    step();
    @(negedge i_clk);
    n_checks++; if (bus.o_Valid !== 1'b1 || bus.o_PC !== 32'h40 || bus.o_Instr !== mem_word(32'h40)) begin n_fail++; $display("FAIL rf_first got v=%0h pc=%h want 1/40", bus.o_Valid, bus.o_PC); end
  endtask

  task automatic test_wrap();
    int idx;
    logic [31:0] exp_pc;
    step();
    bus.i_Redirect = 1'b1; bus.i_Redirect_PC = 32'hFFFF_FFF8;
    @(negedge i_clk);
    step();
    bus.i_Redirect = 1'b0;
    @(negedge i_clk);
    n_checks++; if (bus.o_Valid !== 1'b0) begin n_fail++; $display("FAIL wrap_flush got v=%0h want 0", bus.o_Valid); end
    idx = 0;
    for (int c = 0; c < 12 && idx < 4; c++) begin
      step();
      @(negedge i_clk);
      if (bus.o_Valid && bus.i_Ready) begin
        exp_pc = 32'hFFFF_FFF8 + 32'(4 * idx);
        n_checks++; if (bus.o_PC !== exp_pc || bus.o_Instr !== mem_word(exp_pc)) begin n_fail++; $display("FAIL wrap_seq got pc=%h instr=%h want pc=%h", bus.o_PC, bus.o_Instr, exp_pc); end
        idx++;
      end
    end
    n_checks++; if (idx != 4) begin n_fail++; $display("FAIL wrap_count got %0d want 4", idx); end
  endtask

  task automatic test_misalign();
    step();
    bus.i_Redirect = 1'b1; bus.i_Redirect_PC = 32'h102;
    @(negedge i_clk);
    step();
    bus.i_Redirect = 1'b0;
    @(negedge i_clk);
`ifdef ARVI_FETCH_MISALIGN_CHECK_EN
    n_checks++; if (bus.o_Misaligned !== 1'b1 || bus.o_Bad_PC !== 32'h102) begin n_fail++; $display("FAIL mis_flag got mis=%0h bad=%h want 1/102", bus.o_Misaligned, bus.o_Bad_PC); end
    n_checks++; if (bus.o_IMEM_Req !== 1'b0 || bus.o_Valid !== 1'b0) begin n_fail++; $display("FAIL mis_halt got req=%0h v=%0h want 0/0", bus.o_IMEM_Req, bus.o_Valid); end
    step();
    @(negedge i_clk);
    n_checks++; if (bus.o_IMEM_Req !== 1'b0) begin n_fail++; $display("FAIL mis_halt2 got req=%0h want 0", bus.o_IMEM_Req); end
    step();
    bus.i_Redirect = 1'b1; bus.i_Redirect_PC = 32'h200;
    @(negedge i_clk);
    step();
    bus.i_Redirect = 1'b0;
    @(negedge i_clk);
    n_checks++; if (bus.o_Misaligned !== 1'b0) begin n_fail++; $display("FAIL mis_clear got %0h want 0", bus.o_Misaligned); end
    n_checks++; if (bus.o_IMEM_Req !== 1'b1 || bus.o_IMEM_Addr !== 32'h200) begin n_fail++; $display("FAIL mis_resume got req=%0h addr=%h want 1/200", bus.o_IMEM_Req, bus.o_IMEM_Addr); end
    step();
    @(negedge i_clk);
    n_checks++; if (bus.o_Valid !== 1'b1 || bus.o_PC !== 32'h200) begin n_fail++; $display("FAIL mis_first got v=%0h pc=%h want 1/200", bus.o_Valid, bus.o_PC); end
`else
    n_checks++; if (bus.o_IMEM_Req !== 1'b1 || bus.o_IMEM_Addr !== 32'h100) begin n_fail++; $display("FAIL mis_force got req=%0h addr=%h want 1/100", bus.o_IMEM_Req, bus.o_IMEM_Addr); end
    step();
    @(negedge i_clk);
    n_checks++; if (bus.o_Valid !== 1'b1 || bus.o_PC !== 32'h100 || bus.o_Instr !== mem_word(32'h100)) begin n_fail++; $display("FAIL mis_force_pc got v=%0h pc=%h want 1/100", bus.o_Valid, bus.o_PC); end
`endif
  endtask

  task automatic test_random();
    logic [31:0] exp_pc, tgt, paddr;
    logic pend, after;
    int pops;
    exp_pc = '0; paddr = '0; pend = 1'b0; after = 1'b0; pops = 0;
    for (int c = 0; c < 400; c++) begin
      step();
      ack_tie = 1'b0;
      bus.i_Ready = ($urandom_range(0, 3) != 0);
      ack_man = ($urandom_range(0, 2) == 0);
      bus.i_Redirect = (c == 0) || ($urandom_range(0, 11) == 0);
      tgt = (c == 0) ? 32'h800 : ($urandom & 32'hFFFF_FFFC);
      bus.i_Redirect_PC = tgt;
      @(negedge i_clk);
      if (pend) begin
        n_checks++; if (bus.o_IMEM_Req !== 1'b1 || bus.o_IMEM_Addr !== paddr) begin n_fail++; $display("FAIL rnd_stable c=%0d got req=%0h addr=%h want 1/%h", c, bus.o_IMEM_Req, bus.o_IMEM_Addr, paddr); end
      end
      if (after) begin
        n_checks++; if (bus.o_Valid !== 1'b0) begin n_fail++; $display("FAIL rnd_postredir c=%0d got v=%0h want 0", c, bus.o_Valid); end
      end
      if (bus.o_IMEM_Req) begin
        n_checks++; if (bus.o_IMEM_Addr[1:0] !== 2'b00) begin n_fail++; $display("FAIL rnd_align c=%0d got addr=%h want aligned", c, bus.o_IMEM_Addr); end
      end
      if (bus.o_Valid && bus.i_Ready && !bus.i_Redirect) begin
        n_checks++; if (bus.o_PC !== exp_pc || bus.o_Instr !== mem_word(exp_pc)) begin n_fail++; $display("FAIL rnd_order c=%0d got pc=%h instr=%h want pc=%h", c, bus.o_PC, bus.o_Instr, exp_pc); end
        exp_pc += 32'd4; pops++;
      end
      if (bus.i_Redirect) exp_pc = tgt;
      after = bus.i_Redirect;
      pend  = bus.o_IMEM_Req & ~bus.i_IMEM_Ack;
      paddr = bus.o_IMEM_Addr;
    end
    step();
    bus.i_Redirect = 1'b0;
    n_checks++; if (pops < 20) begin n_fail++; $display("FAIL rnd_progress got %0d pops want >=20", pops); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_reset_mid();
    test_backpressure();
    test_drain();
    test_redirect_full();
    test_wrap();
    test_misalign();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
